stopwatch_timekeeper: RTL
=========================

Name: stopwatch_timekeeper

Overview:
- Consumes the 1 Hz square-wave `tick` from the seconds divider and keeps elapsed stopwatch time as four BCD digits, MM:SS.
- Controlled by start/stop and clear pulses from the button-conditioning stage.
- Drives the seven-segment display mux directly.
- All logic is in the `clk` domain; `tick` is already registered in that domain.

Parameters:
- WRAP, default 1: 1 = roll from 59:59 to 00:00 and set `overflow`; 0 = saturate at 59:59, set `overflow`, force PAUSED.

Ports:
- clk  in  1  system clock, 2.08 MHz
- reset_n  in  1  reset, asynchronous, active-low
- tick  in  1  1 Hz square wave; each rising edge is one elapsed second
- start_stop  in  1  single-cycle pulse; toggles run/pause
- clear  in  1  single-cycle pulse; zeroes time and returns to IDLE
- lap  in  1  single-cycle pulse; present only with STOPWATCH_LAP_HOLD_EN
- sec_ones  out  4  BCD 0-9
- sec_tens  out  4  BCD 0-5
- min_ones  out  4  BCD 0-9
- min_tens  out  4  BCD 0-5
- running  out  1  high in RUNNING
- overflow  out  1  sticky; set when 59:59 is passed

Behaviour:
- Reset (asynchronous, reset_n low):
  - state = IDLE; all digits = 0; running = 0; overflow = 0; tick_d = 0; lap hold off.
- Edge detect:
  - tick_d <= tick every clk.
  - sec_edge = tick & ~tick_d, combinational.
  - A tick rising after edge K is counted at edge K+1, so digits change 1 clk after tick rises.
  - Falling edges are ignored.
- FSM states: IDLE, RUNNING, PAUSED.
  - IDLE: start_stop -> RUNNING.
  - RUNNING: start_stop -> PAUSED.
  - PAUSED: start_stop -> RUNNING.
  - clear from any state -> IDLE and digits = 00:00.
- Counting:
  - Only when the current state is RUNNING and sec_edge = 1.
  - sec_ones increments 0..9 and carries into sec_tens 0..5.
  - sec_tens carries into min_ones 0..9, which carries into min_tens 0..5.
  - Carries are a single-cycle ripple: all digits update on the same clk edge.
- Boundary at 59:59 plus one counted edge:
  - WRAP = 1: digits = 00:00, overflow <= 1, stays RUNNING.
  - WRAP = 0: digits hold 59:59, overflow <= 1, state -> PAUSED.
  - WRAP = 0 with overflow set: start_stop from PAUSED is ignored; only clear recovers.
- Simultaneous events:
  - clear has priority over everything in the same cycle: no count, state IDLE, overflow <= 0.
  - start_stop and sec_edge together are evaluated against the current state:
    - In RUNNING, the edge is counted and state -> PAUSED.
    - In IDLE or PAUSED, the edge is not counted and state -> RUNNING.
- Reset mid-count: immediate asynchronous return to the reset values; no partial digit update is visible.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: STOPWATCH_LAP_HOLD_EN.
- Defined:
  - `lap` port exists and a lap register set mirrors the digits.
  - `lap` pulse in RUNNING: the display outputs freeze at the current value while internal counting continues.
  - A second `lap` pulse, or leaving RUNNING, returns the outputs to live values.
  - clear also drops the hold.
  - lap and a counted edge in the same cycle: the frozen value is the pre-increment value.
- Undefined: no `lap` port, no lap registers; outputs are always the live count.

Decomposition:
- Package stopwatch_pkg:
  - typedef enum logic [1:0] sw_state_t {IDLE, RUNNING, PAUSED}
  - typedef logic [3:0] bcd_t
  - constants SEC_TENS_MAX = 5, MIN_TENS_MAX = 5, BCD_MAX = 9
- Sub-module bcd_digit_counter:
  - Parameter MAX; inputs clk, reset_n, clr, inc.
  - Outputs digit (bcd_t) and carry, where carry = inc & (digit == MAX).
  - Instantiated four times: MAX = 9, 5, 9, 5.

Test Plan:
- Reset, then start_stop, then 5 tick rising edges -> digits 00:05, running = 1; each digit changes exactly 1 clk after the tick rise.
- Run to 00:59, one more edge -> 01:00; pause, 3 edges -> stays 01:00; start_stop, 1 edge -> 01:01.
- Preload to 59:59 via 3599 edges, one more edge:
  - WRAP = 1 -> 00:00, overflow = 1, running = 1.
  - WRAP = 0 -> 59:59, overflow = 1, running = 0, and start_stop is ignored.
- clear together with sec_edge and start_stop at 12:34 -> 00:00, IDLE, overflow = 0, no count.
- start_stop together with sec_edge in RUNNING at 00:10 -> 00:11 and PAUSED; the same in PAUSED -> stays 00:11, then RUNNING.
- With STOPWATCH_LAP_HOLD_EN: lap at 00:20, 4 edges -> outputs 00:20; second lap -> 00:24; reset_n low mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg
//   Shared types and limits for the MM:SS stopwatch timekeeper.
//   sw_state_t : run-control state (IDLE / RUNNING / PAUSED)
//   bcd_t      : one BCD digit
//   *_MAX      : terminal value of each digit position
// ---------------------------------------------------------------------------
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } sw_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t MIN_TENS_MAX = 4'd5;
  localparam bcd_t BCD_MAX      = 4'd9;

endpackage

// File: rtl/bcd_digit_counter.sv
// ---------------------------------------------------------------------------
// bcd_digit_counter
//   One BCD digit that counts 0..MAX and wraps to 0. The carry is
//   combinational so a chain of these ripples a whole MM:SS update within a
//   single clock.
//   Ports:
//     clk     in   system clock
//     reset_n in   asynchronous active-low reset
//     clr     in   synchronous clear to 0 (wins over inc)
//     inc     in   advance by one this cycle
//     digit   out  current value (registered)
//     carry   out  inc & (digit == MAX): next digit should advance
// ---------------------------------------------------------------------------
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = BCD_MAX
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output bcd_t digit,
  output logic carry
);

  assign carry = inc & (digit == MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (inc) begin
      digit <= (digit == MAX) ? '0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_timekeeper.sv
// ---------------------------------------------------------------------------
// stopwatch_timekeeper
//   Counts rising edges of the 1 Hz tick as MM:SS in four BCD digits under
//   start/stop and clear control, and drives the seven-segment mux.
//
//   Build option: STOPWATCH_LAP_HOLD_EN adds the `lap` input and a lap
//   register set that can freeze the displayed value while counting goes on.
//
//   Parameter WRAP: 1 = roll 59:59 -> 00:00 and keep running,
//                   0 = saturate at 59:59 and pause (only clear recovers).
//   Both set the sticky overflow flag.
//
//   Ports:
//     clk        in   system clock
//     reset_n    in   asynchronous active-low reset
//     tick       in   1 Hz square wave, rising edge = one second
//     start_stop in   pulse, toggles run/pause
//     clear      in   pulse, zeroes time and returns to IDLE
//     lap        in   pulse, toggles display hold (lap build only)
//     sec_ones   out  BCD 0-9
//     sec_tens   out  BCD 0-5
//     min_ones   out  BCD 0-9
//     min_tens   out  BCD 0-5
//     running    out  high in RUNNING
//     overflow   out  sticky, set when 59:59 is passed
//
//   state   | meaning
//   --------+--------------------------------------------------
//   IDLE    | cleared, waiting for first start
//   RUNNING | counting tick rising edges
//   PAUSED  | stopped, time held; start resumes unless saturated
// ---------------------------------------------------------------------------
module stopwatch_timekeeper
  import stopwatch_pkg::*;
#(
  parameter int WRAP = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic start_stop,
  input  logic clear,
`ifdef STOPWATCH_LAP_HOLD_EN
  input  logic lap,
`endif
  output bcd_t sec_ones,
  output bcd_t sec_tens,
  output bcd_t min_ones,
  output bcd_t min_tens,
  output logic running,
  output logic overflow
);

  localparam logic WRAP_EN = (WRAP != 0);

  sw_state_t state, state_nxt;
  logic      overflow_nxt;
  logic      tick_d;
  logic      sec_edge;
  logic      count_edge;
  logic      at_max;
  logic      sat_hit;
  logic      inc_so;
  logic      c_so, c_st, c_mo, c_mt;
  bcd_t      live_so, live_st, live_mo, live_mt;

  assign sec_edge = tick & ~tick_d;

  // clear outranks counting in the same cycle
  assign count_edge = (state == RUNNING) & sec_edge & ~clear;

  assign at_max = (live_so == BCD_MAX) & (live_st == SEC_TENS_MAX) &
                  (live_mo == BCD_MAX) & (live_mt == MIN_TENS_MAX);

  // In saturate mode the 59:59 edge is swallowed instead of rippling to 00:00.
  assign sat_hit = count_edge & at_max & ~WRAP_EN;
  assign inc_so  = count_edge & ~sat_hit;

  bcd_digit_counter #(.MAX(BCD_MAX)) u_sec_ones (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clear),
    .inc     (inc_so),
    .digit   (live_so),
    .carry   (c_so)
  );

  bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clear),
    .inc     (c_so),
    .digit   (live_st),
    .carry   (c_st)
  );

  bcd_digit_counter #(.MAX(BCD_MAX)) u_min_ones (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clear),
    .inc     (c_st),
    .digit   (live_mo),
    .carry   (c_mo)
  );

  bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clear),
    .inc     (c_mo),
    .digit   (live_mt),
    .carry   (c_mt)
  );

  always_comb begin
    state_nxt    = state;
    overflow_nxt = overflow;
    if (clear) begin
      state_nxt    = IDLE;
      overflow_nxt = 1'b0;
    end else begin
      // c_mt only fires on the wrapping roll-over; sat_hit covers saturate mode
      if (c_mt || sat_hit) begin
        overflow_nxt = 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start_stop) state_nxt = RUNNING;
        end
        RUNNING: begin
          if (start_stop || sat_hit) state_nxt = PAUSED;
        end
        PAUSED: begin
          // a saturated stopwatch stays parked until cleared
          if (start_stop && (WRAP_EN || !overflow)) state_nxt = RUNNING;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      overflow <= 1'b0;
      running  <= 1'b0;
      tick_d   <= 1'b0;
    end else begin
      state    <= state_nxt;
      overflow <= overflow_nxt;
      running  <= (state_nxt == RUNNING);
      tick_d   <= tick;
    end
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic lap_hold;
  bcd_t lap_so, lap_st, lap_mo, lap_mt;

  // Capture uses the pre-edge digit values, so a lap coinciding with a
  // counted edge freezes the value shown before that second.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lap_hold <= 1'b0;
      lap_so   <= '0;
      lap_st   <= '0;
      lap_mo   <= '0;
      lap_mt   <= '0;
    end else if (clear || (state_nxt != RUNNING)) begin
      lap_hold <= 1'b0;
    end else if (lap && (state == RUNNING)) begin
      if (lap_hold) begin
        lap_hold <= 1'b0;
      end else begin
        lap_hold <= 1'b1;
        lap_so   <= live_so;
        lap_st   <= live_st;
        lap_mo   <= live_mo;
        lap_mt   <= live_mt;
      end
    end
  end

  assign sec_ones = lap_hold ? lap_so : live_so;
  assign sec_tens = lap_hold ? lap_st : live_st;
  assign min_ones = lap_hold ? lap_mo : live_mo;
  assign min_tens = lap_hold ? lap_mt : live_mt;
`else
  assign sec_ones = live_so;
  assign sec_tens = live_st;
  assign min_ones = live_mo;
  assign min_tens = live_mt;
`endif

endmodule
